// File: rtl/stack_op_sequencer_pkg.sv
// Shared definitions for the operand-stack command sequencer: stack op and
// status encodings, command/error/ALU function codes and FSM states.
package stack_op_sequencer_pkg;

  // Stack port encodings (shared with the operand stack itself)
  typedef enum logic [1:0] {
    STK_NONE    = 2'd0,
    STK_PUSH    = 2'd1,
    STK_POP     = 2'd2,
    STK_REPLACE = 2'd3
  } stk_op_e;

  typedef enum logic [2:0] {
    ST_NONE      = 3'd0,
    ST_EMPTY     = 3'd1,
    ST_FULL      = 3'd2,
    ST_UNDERFLOW = 3'd3,
    ST_OVERFLOW  = 3'd4
  } stk_status_e;

  // Command request codes
  typedef enum logic [1:0] {
    CMD_PUSH_IMM = 2'd0,
    CMD_DROP     = 2'd1,
    CMD_UNARY    = 2'd2,
    CMD_BINARY   = 2'd3
  } cmd_e;

  // Response error codes
  typedef enum logic [1:0] {
    ERR_OK        = 2'd0,
    ERR_UNDERFLOW = 2'd1,
    ERR_OVERFLOW  = 2'd2,
    ERR_ILLEGAL   = 2'd3
  } err_e;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_POP     = 3'd1,
    S_FETCH   = 3'd2,
    S_WRITE   = 3'd3,
    S_RESTORE = 3'd4,
    S_RESP    = 3'd5
  } state_e;

  // Binary ALU functions (a = second from top, b = top of stack)
  localparam logic [3:0] FN_ADD  = 4'd0;
  localparam logic [3:0] FN_SUB  = 4'd1;
  localparam logic [3:0] FN_AND  = 4'd2;
  localparam logic [3:0] FN_OR   = 4'd3;
  localparam logic [3:0] FN_XOR  = 4'd4;
  localparam logic [3:0] FN_SHL  = 4'd5;
  localparam logic [3:0] FN_SHR  = 4'd6;
  localparam logic [3:0] FN_EQ   = 4'd7;
  localparam logic [3:0] FN_LTU  = 4'd8;
  localparam logic [3:0] FN_MUL  = 4'd9;

  // Unary ALU functions (operate on top of stack)
  localparam logic [3:0] FN_EQZ  = 4'd0;
  localparam logic [3:0] FN_NOT  = 4'd1;
  localparam logic [3:0] FN_INC  = 4'd2;
  localparam logic [3:0] FN_DEC  = 4'd3;

  // Stack holds no usable operand
  function automatic logic is_no_operand(input logic [2:0] st);
    return (st == ST_EMPTY) || (st == ST_UNDERFLOW);
  endfunction

  // Stack cannot accept another push
  function automatic logic is_full(input logic [2:0] st);
    return (st == ST_FULL) || (st == ST_OVERFLOW);
  endfunction

endpackage

// File: rtl/stack_op_sequencer_alu.sv
// Combinational ALU for the stack sequencer. Results are mod 2^WIDTH.
// Build option: define STACK_SEQ_MUL_EN to enable BINARY fn 9 (low half of
// a*b); without it fn 9 is reported illegal and no multiplier exists.
module stack_seq_alu
  import stack_op_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       i_fn,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_unary,
  output logic [WIDTH-1:0] o_result,
  output logic             o_illegal
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

`ifdef STACK_SEQ_MUL_EN
  logic [WIDTH-1:0] w_mul;
  assign w_mul = i_a * i_b;
`endif

  // Function decode and evaluation
  always_comb begin
    o_result  = '0;
    o_illegal = 1'b0;
    if (i_unary) begin
      case (i_fn)
        FN_EQZ:  o_result = (i_b == '0) ? ONE : '0;
        FN_NOT:  o_result = ~i_b;
        FN_INC:  o_result = i_b + ONE;
        FN_DEC:  o_result = i_b - ONE;
        default: o_illegal = 1'b1;
      endcase
    end else begin
      case (i_fn)
        FN_ADD:  o_result = i_a + i_b;
        FN_SUB:  o_result = i_a - i_b;
        FN_AND:  o_result = i_a & i_b;
        FN_OR:   o_result = i_a | i_b;
        FN_XOR:  o_result = i_a ^ i_b;
        FN_SHL:  o_result = i_a << i_b[SHW-1:0];
        FN_SHR:  o_result = i_a >> i_b[SHW-1:0];
        FN_EQ:   o_result = (i_a == i_b) ? ONE : '0;
        FN_LTU:  o_result = (i_a < i_b) ? ONE : '0;
`ifdef STACK_SEQ_MUL_EN
        FN_MUL:  o_result = w_mul;
`else
        FN_MUL:  o_illegal = 1'b1;
`endif
        default: o_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/stack_op_sequencer.sv
// Operand-stack initiator: expands PUSH_IMM/DROP/UNARY/BINARY commands into
// stack op sequences, guards destructive steps with stack status, and
// returns one response per command. Build option STACK_SEQ_MUL_EN (see ALU).
module stack_op_sequencer
  import stack_op_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_cmd,
  input  logic [3:0]       req_fn,
  input  logic [WIDTH-1:0] req_imm,
  output logic             resp_valid,
  output logic [1:0]       resp_err,
  output logic [WIDTH-1:0] resp_data,
  output logic [1:0]       stk_op,
  output logic [WIDTH-1:0] stk_data,
  input  logic [WIDTH-1:0] stk_tos,
  input  logic [2:0]       stk_status
);

  state_e           r_state;
  logic [1:0]       r_cmd;
  logic [3:0]       r_fn;
  logic [WIDTH-1:0] r_b;

  logic             w_idle;
  logic             w_accept;
  logic [3:0]       w_alu_fn;
  logic [WIDTH-1:0] w_alu_b;
  logic             w_alu_unary;
  logic [WIDTH-1:0] w_alu_result;
  logic             w_alu_illegal;

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = w_idle && req_valid && req_ready;

  // In IDLE the ALU sees the incoming request (legality check, unary
  // result); afterwards it sees the latched fn with a = fresh tos, b = r_b.
  assign w_alu_fn    = w_idle ? req_fn : r_fn;
  assign w_alu_b     = w_idle ? stk_tos : r_b;
  assign w_alu_unary = w_idle && (req_cmd == CMD_UNARY);

  stack_seq_alu #(.WIDTH(WIDTH)) u_alu (
    .i_fn      (w_alu_fn),
    .i_a       (stk_tos),
    .i_b       (w_alu_b),
    .i_unary   (w_alu_unary),
    .o_result  (w_alu_result),
    .o_illegal (w_alu_illegal)
  );

  // Latch command fields and operand b at accept
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_cmd <= req_cmd;
      r_fn  <= req_fn;
      r_b   <= stk_tos;
    end
  end

  // Command sequencing FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= ERR_OK;
      resp_data  <= '0;
      stk_op     <= STK_NONE;
      stk_data   <= '0;
    end else begin
      stk_op     <= STK_NONE;
      resp_valid <= 1'b0;
      req_ready  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (w_accept) begin
            req_ready <= 1'b0;
            case (req_cmd)
              CMD_PUSH_IMM: begin
                if (is_full(stk_status)) begin
                  r_state    <= S_RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= ERR_OVERFLOW;
                  resp_data  <= '0;
                end else begin
                  r_state  <= S_WRITE;
                  stk_op   <= STK_PUSH;
                  stk_data <= req_imm;
                end
              end
              CMD_DROP: begin
                if (is_no_operand(stk_status)) begin
                  r_state    <= S_RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= ERR_UNDERFLOW;
                  resp_data  <= '0;
                end else begin
                  r_state  <= S_WRITE;
                  stk_op   <= STK_POP;
                  stk_data <= '0;
                end
              end
              default: begin
                // Illegal fn wins so that nothing, not even a pop, is issued
                if (w_alu_illegal) begin
                  r_state    <= S_RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= ERR_ILLEGAL;
                  resp_data  <= '0;
                end else if (is_no_operand(stk_status)) begin
                  r_state    <= S_RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= ERR_UNDERFLOW;
                  resp_data  <= '0;
                end else if (req_cmd == CMD_UNARY) begin
                  r_state  <= S_WRITE;
                  stk_op   <= STK_REPLACE;
                  stk_data <= w_alu_result;
                end else begin
                  r_state <= S_POP;
                  stk_op  <= STK_POP;
                end
              end
            endcase
          end
        end
        S_POP: begin
          r_state <= S_FETCH;
        end
        S_FETCH: begin
          // Empty after the pop means b was the only entry: put it back
          if (stk_status == ST_EMPTY) begin
            r_state  <= S_RESTORE;
            stk_op   <= STK_PUSH;
            stk_data <= r_b;
          end else begin
            r_state  <= S_WRITE;
            stk_op   <= STK_REPLACE;
            stk_data <= w_alu_result;
          end
        end
        S_WRITE: begin
          r_state    <= S_RESP;
          resp_valid <= 1'b1;
          resp_err   <= ERR_OK;
          resp_data  <= (r_cmd == CMD_DROP) ? '0 : stk_data;
        end
        S_RESTORE: begin
          r_state    <= S_RESP;
          resp_valid <= 1'b1;
          resp_err   <= ERR_UNDERFLOW;
          resp_data  <= '0;
        end
        S_RESP: begin
          r_state   <= S_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Testbench for stack_op_sequencer: behavioural 8-deep operand stack,
// table of directed commands with hand-computed results, plus reset,
// reset-during-FETCH and overflow sequences.
module tb_stack_op_sequencer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_cmd = 2'd0;
  logic [3:0]       req_fn = 4'd0;
  logic [WIDTH-1:0] req_imm = '0;
  logic             resp_valid;
  logic [1:0]       resp_err;
  logic [WIDTH-1:0] resp_data;
  logic [1:0]       stk_op;
  logic [WIDTH-1:0] stk_data;
  logic [WIDTH-1:0] stk_tos;
  logic [2:0]       stk_status;

  stack_op_sequencer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cmd    (req_cmd),
    .req_fn     (req_fn),
    .req_imm    (req_imm),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_data  (resp_data),
    .stk_op     (stk_op),
    .stk_data   (stk_data),
    .stk_tos    (stk_tos),
    .stk_status (stk_status)
  );

  always #5 clk = ~clk;

  // Behavioural operand stack, 8 entries
  logic [7:0] mem [8];
  logic [3:0] depth = 4'd0;
  logic       evt_udf = 1'b0;
  logic       evt_ovf = 1'b0;
  int         n_push = 0, n_pop = 0, n_repl = 0, n_bad = 0, n_resp = 0, cyc = 0;

  assign stk_tos    = (depth == 4'd0) ? 8'h00 : mem[depth[2:0] - 3'd1];
  assign stk_status = evt_udf ? 3'd3 : evt_ovf ? 3'd4 :
                      (depth == 4'd0) ? 3'd1 : (depth == 4'd8) ? 3'd2 : 3'd0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (resp_valid) n_resp <= n_resp + 1;
    if (reset) begin
      depth   <= 4'd0;
      evt_udf <= 1'b0;
      evt_ovf <= 1'b0;
    end else begin
      evt_udf <= 1'b0;
      evt_ovf <= 1'b0;
      case (stk_op)
        2'd1: begin
          n_push <= n_push + 1;
          if (depth == 4'd8) begin evt_ovf <= 1'b1; n_bad <= n_bad + 1; end
          else begin mem[depth[2:0]] <= stk_data; depth <= depth + 4'd1; end
        end
        2'd2: begin
          n_pop <= n_pop + 1;
          if (depth == 4'd0) begin evt_udf <= 1'b1; n_bad <= n_bad + 1; end
          else depth <= depth - 4'd1;
        end
        2'd3: begin
          n_repl <= n_repl + 1;
          if (depth == 4'd0) begin evt_udf <= 1'b1; n_bad <= n_bad + 1; end
          else mem[depth[2:0] - 3'd1] <= stk_data;
        end
        default: ;
      endcase
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one command from a negedge and wait (bounded) for its response
  task automatic run_cmd(input logic [1:0] c, input logic [3:0] f, input logic [7:0] imm,
                         output logic [1:0] err, output logic [7:0] data, output int lat);
    int n;
    int t0;
    n = 0;
    while (req_ready !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    chk("req_ready_before_cmd", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_cmd   = c;
    req_fn    = f;
    req_imm   = imm;
    t0 = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (resp_valid !== 1'b1 && n < 12) begin @(negedge clk); n++; end
    lat  = (resp_valid === 1'b1) ? (cyc - t0) : -1;
    err  = resp_err;
    data = resp_data;
  endtask

  typedef struct {
    logic [1:0] cmd;
    logic [3:0] fn;
    logic [7:0] imm;
    logic [1:0] err;
    logic [7:0] data;
    int         lat;
    int         dep;
    logic [7:0] tos;
    int         dpush;
    int         dpop;
    int         drepl;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [1:0] c, input logic [3:0] f, input logic [7:0] imm,
                              input logic [1:0] e, input logic [7:0] d, input int lat,
                              input int dep, input logic [7:0] tos,
                              input int dp, input int dq, input int dr);
    vec_t v;
    v.cmd = c; v.fn = f; v.imm = imm; v.err = e; v.data = d; v.lat = lat;
    v.dep = dep; v.tos = tos; v.dpush = dp; v.dpop = dq; v.drepl = dr;
    vecs.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] err;
    logic [7:0] data;
    int lat, p0, q0, r0, s0;

    // cmd fn imm | err data lat depth tos | +push +pop +replace
    add(0, 0, 8'h05, 0, 8'h05, 2, 1, 8'h05, 1, 0, 0);
    add(0, 0, 8'h03, 0, 8'h03, 2, 2, 8'h03, 1, 0, 0);
    add(3, 1, 8'h00, 0, 8'h02, 4, 1, 8'h02, 0, 1, 1);  // SUB 5-3
    add(3, 0, 8'h00, 1, 8'h00, 4, 1, 8'h02, 1, 1, 0);  // ADD at depth 1: restore
    add(1, 0, 8'h00, 0, 8'h00, 2, 0, 8'h00, 0, 1, 0);  // DROP
    add(3, 0, 8'h00, 1, 8'h00, 1, 0, 8'h00, 0, 0, 0);  // ADD on empty
    add(1, 0, 8'h00, 1, 8'h00, 1, 0, 8'h00, 0, 0, 0);  // DROP on empty
    add(2, 1, 8'h00, 1, 8'h00, 1, 0, 8'h00, 0, 0, 0);  // NOT on empty
    add(0, 0, 8'hFF, 0, 8'hFF, 2, 1, 8'hFF, 1, 0, 0);
    add(2, 2, 8'h00, 0, 8'h00, 2, 1, 8'h00, 0, 0, 1);  // INC wraps
    add(2, 0, 8'h00, 0, 8'h01, 2, 1, 8'h01, 0, 0, 1);  // EQZ(0)
    add(2, 3, 8'h00, 0, 8'h00, 2, 1, 8'h00, 0, 0, 1);  // DEC
    add(2, 1, 8'h00, 0, 8'hFF, 2, 1, 8'hFF, 0, 0, 1);  // NOT
    add(2, 4, 8'h00, 3, 8'h00, 1, 1, 8'hFF, 0, 0, 0);  // unknown unary
    add(0, 0, 8'h0C, 0, 8'h0C, 2, 2, 8'h0C, 1, 0, 0);
    add(0, 0, 8'h02, 0, 8'h02, 2, 3, 8'h02, 1, 0, 0);
    add(3, 5, 8'h00, 0, 8'h30, 4, 2, 8'h30, 0, 1, 1);  // SHL 0x0C<<2
    add(0, 0, 8'h34, 0, 8'h34, 2, 3, 8'h34, 1, 0, 0);
    add(3, 4, 8'h00, 0, 8'h04, 4, 2, 8'h04, 0, 1, 1);  // XOR
    add(0, 0, 8'h04, 0, 8'h04, 2, 3, 8'h04, 1, 0, 0);
    add(3, 7, 8'h00, 0, 8'h01, 4, 2, 8'h01, 0, 1, 1);  // EQ
    add(0, 0, 8'h05, 0, 8'h05, 2, 3, 8'h05, 1, 0, 0);
    add(3, 8, 8'h00, 0, 8'h01, 4, 2, 8'h01, 0, 1, 1);  // LT_U 1<5
    add(3, 12, 8'h00, 3, 8'h00, 1, 2, 8'h01, 0, 0, 0); // unknown binary
    add(0, 0, 8'h0F, 0, 8'h0F, 2, 3, 8'h0F, 1, 0, 0);
    add(3, 2, 8'h00, 0, 8'h01, 4, 2, 8'h01, 0, 1, 1);  // AND
    add(0, 0, 8'h80, 0, 8'h80, 2, 3, 8'h80, 1, 0, 0);
    add(3, 3, 8'h00, 0, 8'h81, 4, 2, 8'h81, 0, 1, 1);  // OR
    add(0, 0, 8'h03, 0, 8'h03, 2, 3, 8'h03, 1, 0, 0);
    add(3, 6, 8'h00, 0, 8'h10, 4, 2, 8'h10, 0, 1, 1);  // SHR_U 0x81>>3
    add(3, 0, 8'h00, 0, 8'h0F, 4, 1, 8'h0F, 0, 1, 1);  // ADD 0xFF+0x10 wraps
    add(0, 0, 8'h06, 0, 8'h06, 2, 2, 8'h06, 1, 0, 0);
`ifdef STACK_SEQ_MUL_EN
    add(3, 9, 8'h00, 0, 8'h5A, 4, 1, 8'h5A, 0, 1, 1);  // MUL 0x0F*6
`else
    add(3, 9, 8'h00, 3, 8'h00, 1, 2, 8'h06, 0, 0, 0);  // MUL not built
`endif

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready",  {31'd0, req_ready},  32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_err",   {30'd0, resp_err},   32'd0);
    chk("rst_resp_data",  {24'd0, resp_data},  32'd0);
    chk("rst_stk_op",     {30'd0, stk_op},     32'd0);
    chk("rst_stk_data",   {24'd0, stk_data},   32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // Table-driven commands
    for (int i = 0; i < vecs.size(); i++) begin
      p0 = n_push; q0 = n_pop; r0 = n_repl;
      run_cmd(vecs[i].cmd, vecs[i].fn, vecs[i].imm, err, data, lat);
      chk($sformatf("v%0d_err", i),   {30'd0, err},  {30'd0, vecs[i].err});
      chk($sformatf("v%0d_data", i),  {24'd0, data}, {24'd0, vecs[i].data});
      chk($sformatf("v%0d_lat", i),   lat,           vecs[i].lat);
      chk($sformatf("v%0d_depth", i), {28'd0, depth}, vecs[i].dep);
      chk($sformatf("v%0d_tos", i),   {24'd0, stk_tos}, {24'd0, vecs[i].tos});
      chk($sformatf("v%0d_push", i),  n_push - p0,   vecs[i].dpush);
      chk($sformatf("v%0d_pop", i),   n_pop - q0,    vecs[i].dpop);
      chk($sformatf("v%0d_repl", i),  n_repl - r0,   vecs[i].drepl);
      @(negedge clk);
      chk($sformatf("v%0d_pulse", i), {31'd0, resp_valid}, 32'd0);
    end

    // Reset asserted while a BINARY sits in FETCH
    s0 = n_resp;
    chk("rf_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_cmd = 2'd3; req_fn = 4'd0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rf_pop_issued", {30'd0, stk_op}, 32'd2);
    @(negedge clk);
    chk("rf_fetch_op", {30'd0, stk_op}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rf_op_none",   {30'd0, stk_op},     32'd0);
    chk("rf_no_resp",   {31'd0, resp_valid}, 32'd0);
    chk("rf_ready_low", {31'd0, req_ready},  32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("rf_ready_high", {31'd0, req_ready}, 32'd1);
    chk("rf_resp_count", n_resp - s0, 32'd0);
    chk("rf_op_idle",    {30'd0, stk_op}, 32'd0);

    // Fill the stack, then push once more
    run_cmd(2'd0, 4'd0, 8'h11, err, data, lat);
    chk("fill0_err", {30'd0, err}, 32'd0);
    chk("fill0_lat", lat, 32'd2);
    @(negedge clk);
    for (int k = 1; k < 8; k++) begin
      run_cmd(2'd0, 4'd0, 8'h20 + 8'(k), err, data, lat);
      chk($sformatf("fill%0d_err", k), {30'd0, err}, 32'd0);
      @(negedge clk);
    end
    chk("full_status", {29'd0, stk_status}, 32'd2);
    p0 = n_push;
    run_cmd(2'd0, 4'd0, 8'hAA, err, data, lat);
    chk("ovf_err",    {30'd0, err},  32'd2);
    chk("ovf_data",   {24'd0, data}, 32'd0);
    chk("ovf_lat",    lat,           32'd1);
    chk("ovf_push",   n_push - p0,   32'd0);
    chk("ovf_status", {29'd0, stk_status}, 32'd2);
    chk("ovf_tos",    {24'd0, stk_tos},    32'h27);
    @(negedge clk);

    chk("stack_protocol_errors", n_bad, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
